// File: rtl/cpu_pkt_pkg.sv
// Shared widths, field types and small helpers for the CPU packet transmit path.
package cpu_pkt_pkg;

    localparam int PAYLOAD = 32;
    localparam int FLAGS   = 11;
    localparam int ADDR    = 20;
    localparam int ID      = 2;
    localparam int EOP     = 1;

    // Largest requester count addressable by the ID field.
    localparam int MAX_REQ = 1 << ID;

    typedef logic [PAYLOAD-1:0] pkt_data_payload_t;
    typedef logic [FLAGS-1:0]   pkt_data_flags_t;
    typedef logic [ADDR-1:0]    pkt_data_addr_t;
    typedef logic [EOP-1:0]     pkt_ctl_eop_t;
    typedef logic [ID-1:0]      pkt_ctl_id_t;

    // One extra bit so pointer + offset never overflows before the modulo fold.
    typedef logic [ID:0]        pkt_id_sum_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Cyclic successor of a requester index within n requesters.
    function automatic pkt_ctl_id_t next_id(input pkt_ctl_id_t id, input int unsigned n);
        if ((int'(id) + 1) >= int'(n)) begin
            return '0;
        end
        return id + pkt_ctl_id_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, cyclically.
module rr_arbiter
    import cpu_pkt_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  pkt_ctl_id_t        rr_ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output pkt_ctl_id_t        gnt_bin,
    output logic               gnt_any
);

    // Requests padded to the full ID range so any ID value indexes safely.
    logic [MAX_REQ-1:0] req_ext;
    pkt_ctl_id_t        cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    assign req_ext = MAX_REQ'(req);

    // cand[k] is the requester examined k-th when starting from rr_ptr.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        pkt_id_sum_t sum;
        assign sum      = {1'b0, rr_ptr} + pkt_id_sum_t'(gi);
        assign cand[gi] = (sum >= pkt_id_sum_t'(NUM_REQ))
                        ? pkt_ctl_id_t'(sum - pkt_id_sum_t'(NUM_REQ))
                        : pkt_ctl_id_t'(sum);
        assign hit[gi]  = req_ext[cand[gi]];
    end

    // Lowest search offset with an active request wins; scan downward so it lands last.
    always_comb begin
        gnt_bin = '0;
        gnt_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                gnt_any = 1'b1;
                gnt_bin = cand[k];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign gnt_onehot[gi] = gnt_any && (gnt_bin == pkt_ctl_id_t'(gi));
    end

endmodule

// File: rtl/pkt_tx_arbiter.sv
// Packet-locked round-robin arbiter merging CPU transmit requesters onto one
// registered co-processor beat stream. A grant holds until its eop beat is taken.
module pkt_tx_arbiter
    import cpu_pkt_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*PAYLOAD-1:0] req_data,
    input  logic [NUM_REQ*FLAGS-1:0]  req_flags,
    input  logic [NUM_REQ*ADDR-1:0]   req_proc_id,
    input  logic [NUM_REQ*EOP-1:0]    req_eop,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output pkt_data_payload_t         out_data,
    output pkt_data_flags_t           out_flags,
    output pkt_data_addr_t            out_proc_id,
    output pkt_ctl_eop_t              out_eop,
    output pkt_ctl_id_t               out_id,
    input  logic                      out_ready
);

    arb_state_e         state_q, state_d;
    pkt_ctl_id_t        grant_q, grant_d;
    logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
    pkt_ctl_id_t        rr_ptr_q, rr_ptr_d;

    logic               out_valid_q, out_valid_d;
    pkt_data_payload_t  out_data_q, out_data_d;
    pkt_data_flags_t    out_flags_q, out_flags_d;
    pkt_data_addr_t     out_proc_id_q, out_proc_id_d;
    pkt_ctl_eop_t       out_eop_q, out_eop_d;
    pkt_ctl_id_t        out_id_q, out_id_d;

    // Per-requester fields unpacked and padded to the full ID range.
    pkt_data_payload_t  data_arr [MAX_REQ];
    pkt_data_flags_t    flags_arr [MAX_REQ];
    pkt_data_addr_t     addr_arr [MAX_REQ];
    pkt_ctl_eop_t       eop_arr [MAX_REQ];
    logic [MAX_REQ-1:0] valid_ext;

    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
        if (gi < NUM_REQ) begin : g_real
            assign data_arr[gi]  = req_data[gi*PAYLOAD +: PAYLOAD];
            assign flags_arr[gi] = req_flags[gi*FLAGS +: FLAGS];
            assign addr_arr[gi]  = req_proc_id[gi*ADDR +: ADDR];
            assign eop_arr[gi]   = req_eop[gi*EOP +: EOP];
            assign valid_ext[gi] = req_valid[gi];
        end else begin : g_pad
            assign data_arr[gi]  = '0;
            assign flags_arr[gi] = '0;
            assign addr_arr[gi]  = '0;
            assign eop_arr[gi]   = '0;
            assign valid_ext[gi] = 1'b0;
        end
    end

    logic [NUM_REQ-1:0] arb_onehot;
    pkt_ctl_id_t        arb_bin;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .rr_ptr     (rr_ptr_q),
        .gnt_onehot (arb_onehot),
        .gnt_bin    (arb_bin),
        .gnt_any    (arb_any)
    );

    // The output register can take a beat when empty or draining this cycle.
    logic can_load;
    logic locked;
    logic accept;

    assign can_load  = !out_valid_q || out_ready;
    assign locked    = (state_q == ST_LOCKED);
    assign accept    = locked && valid_ext[grant_q] && can_load;
    assign req_ready = (locked && can_load) ? grant_oh_q : '0;

    // Next-state for arbitration FSM, grant/pointer and output register.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_oh_d    = grant_oh_q;
        rr_ptr_d      = rr_ptr_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_flags_d   = out_flags_q;
        out_proc_id_d = out_proc_id_q;
        out_eop_d     = out_eop_q;
        out_id_d      = out_id_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d    = arb_bin;
                    grant_oh_d = arb_onehot;
                    state_d    = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // Only the last beat of a packet releases the grant.
                if (accept && (eop_arr[grant_q] != '0)) begin
                    rr_ptr_d = next_id(grant_q, NUM_REQ);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            out_valid_d   = 1'b1;
            out_data_d    = data_arr[grant_q];
            out_flags_d   = flags_arr[grant_q];
            out_proc_id_d = addr_arr[grant_q];
            out_eop_d     = eop_arr[grant_q];
            out_id_d      = grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // All state registers; reset drops any partial packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_oh_q    <= '0;
            rr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_flags_q   <= '0;
            out_proc_id_q <= '0;
            out_eop_q     <= '0;
            out_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_oh_q    <= grant_oh_d;
            rr_ptr_q      <= rr_ptr_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_flags_q   <= out_flags_d;
            out_proc_id_q <= out_proc_id_d;
            out_eop_q     <= out_eop_d;
            out_id_q      <= out_id_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_flags   = out_flags_q;
    assign out_proc_id = out_proc_id_q;
    assign out_eop     = out_eop_q;
    assign out_id      = out_id_q;

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Scoreboard bench for pkt_tx_arbiter: packet-level round-robin reference model,
// randomized traffic plus directed latency, contention, backpressure, gap and reset cases.
module tb_pkt_tx_arbiter;
    import cpu_pkt_pkg::*;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N*PAYLOAD-1:0] req_data = '0;
    logic [N*FLAGS-1:0]   req_flags = '0;
    logic [N*ADDR-1:0]    req_proc_id = '0;
    logic [N*EOP-1:0]     req_eop = '0;
    logic [N-1:0]         req_ready;
    logic                 out_valid;
    pkt_data_payload_t    out_data;
    pkt_data_flags_t      out_flags;
    pkt_data_addr_t       out_proc_id;
    pkt_ctl_eop_t         out_eop;
    pkt_ctl_id_t          out_id;
    logic                 out_ready = 1'b0;

    always #5 clk = ~clk;

    pkt_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_flags   (req_flags),
        .req_proc_id (req_proc_id),
        .req_eop     (req_eop),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_flags   (out_flags),
        .out_proc_id (out_proc_id),
        .out_eop     (out_eop),
        .out_id      (out_id),
        .out_ready   (out_ready)
    );

    typedef struct {
        logic [31:0] data;
        logic [10:0] flags;
        logic [19:0] proc_id;
        logic        eop;
    } beat_t;

    typedef struct {
        beat_t b;
        int    id;
    } exp_t;

    beat_t drv_q [N][$];   // beats still to be offered by each requester
    beat_t mdl_q [N][$];   // packets not yet scheduled by the reference model
    exp_t  exp_q [$];      // expected output beats, in order
    int    mdl_ptr = 0;

    int n_vec = 0;
    int n_bad = 0;
    int pops  = 0;

    int gap_pct   = 0;
    int rdy_pct   = 100;
    int hold_low  = 0;
    int force_gap = 0;
    int gap_req   = 0;
    logic [N-1:0] mid = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Queue one packet on requester i for both the driver and the model.
    task automatic add_pkt(input int i, input int nb, input logic [31:0] base, input bit rnd);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.data    = rnd ? $urandom : base + k;
            b.flags   = rnd ? 11'($urandom) : 11'(k);
            b.proc_id = rnd ? 20'($urandom) : base[19:0];
            b.eop     = (k == nb - 1);
            drv_q[i].push_back(b);
            mdl_q[i].push_back(b);
        end
    endtask

    // Packet-level round robin: serve the first pending requester at or after the
    // pointer, emit its whole head packet, move the pointer past it.
    task automatic model_run();
        int  pick;
        bit  done;
        exp_t e;
        forever begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && mdl_q[(mdl_ptr + k) % N].size() > 0) pick = (mdl_ptr + k) % N;
            end
            if (pick < 0) break;
            done = 0;
            while (!done) begin
                e.b  = mdl_q[pick].pop_front();
                e.id = pick;
                exp_q.push_back(e);
                done = e.b.eop;
            end
            mdl_ptr = (pick + 1) % N;
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) return 1'b1;
        return (exp_q.size() != 0) || (out_valid === 1'b1);
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while (busy() && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) timeout_fail(name);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            mdl_q[i].delete();
        end
        exp_q.delete();
        mid     = '0;
        mdl_ptr = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},   32'(out_valid), 32'h0);
        check({tag, "_out_data"},    out_data, 32'h0);
        check({tag, "_out_flags"},   32'(out_flags), 32'h0);
        check({tag, "_out_proc_id"}, 32'(out_proc_id), 32'h0);
        check({tag, "_out_eop"},     32'(out_eop), 32'h0);
        check({tag, "_out_id"},      32'(out_id), 32'h0);
        check({tag, "_req_ready"},   32'(req_ready), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requester drivers and out_ready generator; update just after each rising edge.
    initial begin : driver
        logic [N-1:0] acc;
        beat_t        b;
        bit           v;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rst_n && acc[i] && drv_q[i].size() > 0) begin
                    mid[i] = !drv_q[i][0].eop;
                    drv_q[i].delete(0);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (drv_q[i].size() == 0) begin
                    req_valid[i]            = 1'b0;
                    req_data[i*32 +: 32]    = '0;
                    req_flags[i*11 +: 11]   = '0;
                    req_proc_id[i*20 +: 20] = '0;
                    req_eop[i]              = 1'b0;
                end else begin
                    b = drv_q[i][0];
                    v = 1'b1;
                    if (mid[i]) begin
                        if (force_gap > 0 && i == gap_req) begin
                            v = 1'b0;
                            force_gap--;
                        end else if (int'($urandom_range(99)) < gap_pct) begin
                            v = 1'b0;
                        end
                    end
                    req_valid[i]            = v;
                    req_data[i*32 +: 32]    = b.data;
                    req_flags[i*11 +: 11]   = b.flags;
                    req_proc_id[i*20 +: 20] = b.proc_id;
                    req_eop[i]              = b.eop;
                end
            end
            if (hold_low > 0) begin
                out_ready = 1'b0;
                hold_low--;
            end else begin
                out_ready = (int'($urandom_range(99)) < rdy_pct);
            end
        end
    end

    // Monitor: every beat taken by the co-processor is checked against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                pops++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat: got id=%0d data=%08h eop=%0b, required no beat",
                             out_id, out_data, out_eop);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.b.data || out_flags !== e.b.flags ||
                        out_proc_id !== e.b.proc_id || out_eop !== e.b.eop ||
                        int'(out_id) != e.id) begin
                        n_bad++;
                        $display("FAIL beat: got id=%0d data=%08h flags=%03h addr=%05h eop=%0b, required id=%0d data=%08h flags=%03h addr=%05h eop=%0b",
                                 out_id, out_data, out_flags, out_proc_id, out_eop,
                                 e.id, e.b.data, e.b.flags, e.b.proc_id, e.b.eop);
                    end else begin
                        $display("beat ok: id=%0d data=%08h eop=%0b", out_id, out_data, out_eop);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        int lat;
        int rdy_lat;
        int base;
        int mask;

        // Asynchronous reset, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single requester, 3-beat packet, latency and streaming.
        rdy_pct = 100;
        gap_pct = 0;
        @(negedge clk);
        add_pkt(1, 3, 32'hA0, 1'b0);
        model_run();
        @(posedge clk);
        #2;
        lat = 0;
        rdy_lat = -1;
        while (lat < 20) begin
            @(negedge clk);
            if (rdy_lat < 0 && req_ready[1]) rdy_lat = lat;
            if (out_valid) break;
            lat++;
        end
        check("latency_req_ready", 32'(rdy_lat), 32'd1);
        check("latency_out_valid", 32'(lat), 32'd2);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("single_data", out_data, 32'hA0 + 32'(k));
            check("single_eop",  32'(out_eop), (k == 2) ? 32'd1 : 32'd0);
            check("single_id",   32'(out_id), 32'd1);
        end
        wait_drain("single_drain", 200);

        // Contention from reset: requesters 0, 2, 3, two single-beat packets each.
        do_reset();
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 1, 32'h100 + 32'(r), 1'b0);
            add_pkt(2, 1, 32'h200 + 32'(r), 1'b0);
            add_pkt(3, 1, 32'h300 + 32'(r), 1'b0);
        end
        model_run();
        wait_drain("contention_drain", 200);

        // Backpressure: out_ready low 5 cycles in the middle of a 6-beat packet.
        base = pops;
        @(negedge clk);
        add_pkt(2, 6, 32'hB0, 1'b0);
        model_run();
        t = 0;
        while (pops < base + 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout_fail("bp_start");
        hold_low = 5;
        @(posedge clk);
        #2;
        repeat (5) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_out_valid", 32'(out_valid), 32'h1);
        end
        wait_drain("bp_drain", 200);

        // Granted requester 1 pauses 2 cycles while requester 0 waits.
        @(negedge clk);
        add_pkt(1, 4, 32'hC0, 1'b0);
        model_run();
        t = 0;
        while (!(req_valid[1] && req_ready[1]) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout_fail("gap_start");
        gap_req = 1;
        force_gap = 2;
        add_pkt(0, 1, 32'hD0, 1'b0);
        model_run();
        repeat (2) begin
            @(negedge clk);
            check("gap_req_ready", 32'(req_ready), 32'h2);
        end
        wait_drain("gap_drain", 200);

        // Randomized traffic with gaps and random backpressure.
        gap_pct = 25;
        rdy_pct = 65;
        for (int it = 0; it < 30; it++) begin
            @(negedge clk);
            mask = int'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    for (int p = int'($urandom_range(1, 3)); p > 0; p--)
                        add_pkt(i, int'($urandom_range(1, 5)), 32'h0, 1'b1);
                end
            end
            model_run();
            wait_drain("random_drain", 3000);
        end

        // Reset in the middle of a 4-beat packet; arbitration restarts at requester 0.
        gap_pct = 0;
        rdy_pct = 100;
        @(negedge clk);
        add_pkt(1, 1, 32'hE0, 1'b0);
        model_run();
        wait_drain("rst_pre_drain", 200);
        @(negedge clk);
        add_pkt(2, 4, 32'hF0, 1'b0);
        model_run();
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout_fail("rst_mid_start");
        #1 rst_n = 1'b0;
        clear_all();
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_pkt(3, 1, 32'h33, 1'b0);
        add_pkt(1, 1, 32'h11, 1'b0);
        model_run();
        wait_drain("rst_post_drain", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
